regfile_reader: RTL

Debug read-out engine for the 32×32 register file. On a start request it walks a contiguous (wrap-around) range of register addresses through one of the register file's combinational read ports. It streams each `{address, word}` pair out over a valid/ready handshake and keeps a running XOR checksum. It sits beside the datapath and connects to the read port the datapath leaves free. Intended users are the lab debug UART bridge and the testbench scoreboard.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_reader.sv | 113 +++++++++++
 2 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg : register-file widths and read-out engine state type    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_reader : walks a wrap-around register range, streams         |
// | {addr, word} over valid/ready and keeps an XOR checksum. Rev 1.0     |
// +----------------------------------------------------------------------+
module regfile_reader
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_last;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_done;
  logic [DATA_W-1:0] r_checksum;
  logic [ADDR_W-1:0] w_next;

  // Address arithmetic is modulo 2**ADDR_W, giving the wrap from 31 to 0.
  assign w_next = r_cur + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      r_last      <= '0;
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_checksum  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_last     <= last_addr;
            r_cur      <= first_addr;
            r_rd_addr  <= first_addr;
            r_checksum <= '0;
            r_state    <= READ;
          end
        end
        READ: begin
          r_rd_addr <= '0;
          if (abort) begin
            r_state <= IDLE;
          end else begin
            r_out_data  <= rd_data;
            r_out_addr  <= r_cur;
            r_out_valid <= 1'b1;
            r_state     <= SEND;
          end
        end
        SEND: begin
          // Abort wins over a same-cycle handshake: that word is not counted.
          if (abort) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end else if (out_ready) begin
            r_checksum  <= r_checksum ^ r_out_data;
            r_out_valid <= 1'b0;
            if (r_cur == r_last) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_cur     <= w_next;
              r_rd_addr <= w_next;
              r_state   <= READ;
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_rd_addr   <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign rd_addr   = r_rd_addr;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign checksum  = r_checksum;

endmodule
`default_nettype wire
